motor_direction_fsm: RTL
========================

MOTOR_DIRECTION_FSM -- requirements
Module: motor_direction_fsm

Interface
REQ-001 Parameter STOP_CM, default 20: an obstacle sample is any valid distance strictly below this, in cm.
REQ-002 Parameter CLEAR_CM, default 30: a clear sample is any valid distance at or above this, in cm; CLEAR_CM SHALL exceed STOP_CM.
REQ-003 Parameter CONFIRM_N, default 3: number of consecutive samples needed to set or clear the obstacle flag.
REQ-004 Parameter BACKOFF_CYCLES, default 25_000_000: reverse duration, 0.5 s at 50 MHz.
REQ-005 Parameter DWELL_CYCLES, default 50_000_000: minimum stop time before resuming forward.
REQ-006 Parameter TIMEOUT_CYCLES, default 10_000_000: sensor-silence limit (see Configuration).
REQ-007 clk  in  1  50 MHz system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 distance_valid  in  1  single-cycle strobe; distance_cm is valid when it is high.
REQ-010 distance_cm  in  10  ultrasonic range, unsigned, cm.
REQ-011 start_cmd  in  1  level or pulse; requests forward motion.
REQ-012 stop_cmd  in  1  level or pulse; requests halt.
REQ-013 direction  out  2  registered motion command to the continuous motor controller: 00 forward, 01 reverse, 10 stop.
REQ-014 state_o  out  2  current FSM state, debug only.
REQ-015 obstacle  out  1  registered, filtered obstacle flag.
REQ-016 fault  out  1  sticky sensor-timeout flag.

Function
REQ-017 Filter: on a valid near sample, near_cnt SHALL increment, saturating at CONFIRM_N, and clear_cnt SHALL reset to 0.
REQ-018 Filter: on a valid clear sample, clear_cnt SHALL increment, saturating at CONFIRM_N, and near_cnt SHALL reset to 0.
REQ-019 Filter: a valid sample in the band [STOP_CM, CLEAR_CM) SHALL leave both counts unchanged; cycles without distance_valid SHALL leave them unchanged.
REQ-020 obstacle SHALL set on the edge where near_cnt reaches CONFIRM_N and clear on the edge where clear_cnt reaches CONFIRM_N.
REQ-021 FSM states: IDLE (stop), FORWARD (forward), BACKOFF (reverse), WAIT (stop); direction SHALL be registered from the next state, so it changes on the same edge as state.
REQ-022 IDLE->FORWARD when start_cmd=1, stop_cmd=0, obstacle=0; start_cmd while obstacle=1 SHALL be ignored, with no latching.
REQ-023 FORWARD->BACKOFF when obstacle=1; the backoff counter is loaded with BACKOFF_CYCLES-1 on that edge.
REQ-024 BACKOFF SHALL hold reverse for exactly BACKOFF_CYCLES cycles, then go to WAIT, loading the dwell counter with DWELL_CYCLES-1.
REQ-025 WAIT->FORWARD once the dwell counter reaches 0 and obstacle=0; if obstacle=1 at expiry, the FSM SHALL remain in WAIT until obstacle clears.
REQ-026 stop_cmd=1 SHALL force IDLE from any state on the next edge.
REQ-027 stop_cmd has priority over start_cmd, over obstacle, and over counter expiry.
REQ-028 Latency: direction SHALL leave forward exactly 2 cycles after the confirming distance_valid cycle (flag register, then state register).
REQ-029 Encoding 11 SHALL never be driven on direction.
REQ-030 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap.

Reset
REQ-031 On rst: state IDLE, direction 10, state_o 00, obstacle 0, fault 0, all counters 0.
REQ-032 rst asserted mid-BACKOFF or mid-WAIT SHALL abort the manoeuvre; direction SHALL read 10 on the first edge with rst high.

Configuration
REQ-033 With SENSOR_WATCHDOG_EN defined: a silence counter SHALL reset on every distance_valid.
REQ-034 With SENSOR_WATCHDOG_EN defined: when the silence counter reaches TIMEOUT_CYCLES in FORWARD or BACKOFF, the FSM SHALL go to IDLE and set fault.
REQ-035 With SENSOR_WATCHDOG_EN defined: fault SHALL clear on an accepted start_cmd or on rst.
REQ-036 With SENSOR_WATCHDOG_EN undefined: no silence counter SHALL exist, fault SHALL be tied 0, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-037 Package motor_pkg SHALL hold the dir_t enum (DIR_FORWARD=2'b00, DIR_REVERSE=2'b01, DIR_STOP=2'b10) and the fsm_state_t enum (IDLE, FORWARD, BACKOFF, WAIT).
REQ-038 The consumer of direction SHALL import dir_t from motor_pkg.
REQ-039 The filter of REQ-017 to REQ-020 SHALL be sub-module obstacle_filter, carrying STOP_CM, CLEAR_CM and CONFIRM_N.

Verification (bench overrides: BACKOFF_CYCLES=8, DWELL_CYCLES=16, TIMEOUT_CYCLES=40, CONFIRM_N=3)
REQ-040 Reset, then a start_cmd pulse with clear sensor: direction 10 -> 00 one edge after start.
REQ-041 In FORWARD, three valid samples of 15 cm: obstacle=1, direction=01 two cycles after the third sample; reverse held 8 cycles; then 10 for 16 cycles; then 00 once three 35 cm samples are seen.
REQ-042 Samples alternating 15, 25, 15 cm: obstacle stays 0, since the band sample holds the count; a following fourth sample of 15 cm sets obstacle.
REQ-043 start_cmd and stop_cmd high together in IDLE, then stop_cmd high mid-BACKOFF: IDLE held in the first case; direction=10 next edge in the second.
REQ-044 SENSOR_WATCHDOG_EN defined, FORWARD, no distance_valid for 40 cycles: IDLE, fault=1; the next start_cmd clears fault. Build without the macro: fault stays 0 throughout.
REQ-045 rst pulsed on cycle 4 of BACKOFF: direction=10, obstacle=0, and the next start_cmd with clear samples restarts cleanly.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types for the obstacle-avoiding motor direction controller.
// Direction encoding is consumed by the continuous motor controller.
package motor_pkg;

    typedef enum logic [1:0] {
        DIR_FORWARD = 2'b00,
        DIR_REVERSE = 2'b01,
        DIR_STOP    = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FORWARD = 2'b01,
        BACKOFF = 2'b10,
        WAIT    = 2'b11
    } fsm_state_t;

    // Counter width for a count of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/obstacle_filter.sv
// Debounces ultrasonic range samples into a registered obstacle flag with
// hysteresis: near below STOP_CM, clear at or above CLEAR_CM, band holds.
module obstacle_filter
    import motor_pkg::*;
#(
    parameter int STOP_CM   = 20,
    parameter int CLEAR_CM  = 30,
    parameter int CONFIRM_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       distance_valid,
    input  logic [9:0] distance_cm,
    output logic       obstacle
);

    localparam int             CW      = cnt_w(CONFIRM_N + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(CONFIRM_N);
    localparam logic [9:0]     STOP_V  = 10'(STOP_CM);
    localparam logic [9:0]     CLEAR_V = 10'(CLEAR_CM);

    if (CLEAR_CM <= STOP_CM || CONFIRM_N < 1) begin : g_bad_params
        $error("obstacle_filter: CLEAR_CM must exceed STOP_CM and CONFIRM_N must be >= 1");
    end

    logic [CW-1:0] near_cnt;
    logic [CW-1:0] clear_cnt;
    logic          near;
    logic          clear;

    assign near  = distance_valid && (distance_cm <  STOP_V);
    assign clear = distance_valid && (distance_cm >= CLEAR_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            near_cnt  <= '0;
            clear_cnt <= '0;
            obstacle  <= 1'b0;
        end else if (near) begin
            clear_cnt <= '0;
            if (near_cnt != CNT_MAX)
                near_cnt <= near_cnt + CW'(1);
            // flag follows on the same edge the count reaches CONFIRM_N
            if (near_cnt >= CNT_MAX - CW'(1))
                obstacle <= 1'b1;
        end else if (clear) begin
            near_cnt <= '0;
            if (clear_cnt != CNT_MAX)
                clear_cnt <= clear_cnt + CW'(1);
            if (clear_cnt >= CNT_MAX - CW'(1))
                obstacle <= 1'b0;
        end
    end

endmodule

// File: rtl/motor_direction_fsm.sv
// Forward / back-off / dwell sequencer driving the motor direction command.
// Optional sensor-silence watchdog enabled by defining SENSOR_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | stopped, waiting for start_cmd with no obstacle
// FORWARD | driving forward until the filtered obstacle flag sets
// BACKOFF | reversing for BACKOFF_CYCLES
// WAIT    | stopped for at least DWELL_CYCLES, then until obstacle clears
module motor_direction_fsm
    import motor_pkg::*;
#(
    parameter int STOP_CM        = 20,
    parameter int CLEAR_CM       = 30,
    parameter int CONFIRM_N      = 3,
    parameter int BACKOFF_CYCLES = 25_000_000,
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       distance_valid,
    input  logic [9:0] distance_cm,
    input  logic       start_cmd,
    input  logic       stop_cmd,
    output logic [1:0] direction,
    output logic [1:0] state_o,
    output logic       obstacle,
    output logic       fault
);

    localparam int            BW      = cnt_w(BACKOFF_CYCLES);
    localparam int            DW      = cnt_w(DWELL_CYCLES);
    localparam logic [BW-1:0] BO_LOAD = BW'(BACKOFF_CYCLES - 1);
    localparam logic [DW-1:0] DW_LOAD = DW'(DWELL_CYCLES - 1);

    if (BACKOFF_CYCLES < 1 || DWELL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("motor_direction_fsm: cycle parameters must be >= 1");
    end

    fsm_state_t    state;
    dir_t          dir_q;
    logic [BW-1:0] bo_cnt;
    logic [DW-1:0] dw_cnt;

    obstacle_filter #(
        .STOP_CM   (STOP_CM),
        .CLEAR_CM  (CLEAR_CM),
        .CONFIRM_N (CONFIRM_N)
    ) u_filter (
        .clk            (clk),
        .rst            (rst),
        .distance_valid (distance_valid),
        .distance_cm    (distance_cm),
        .obstacle       (obstacle)
    );

`ifdef SENSOR_WATCHDOG_EN
    localparam int            SW       = cnt_w(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SIL_LAST = SW'(TIMEOUT_CYCLES - 1);

    logic [SW-1:0] silence_cnt;
    logic          moving;
    logic          timeout;
    logic          fault_q;

    assign moving  = (state == FORWARD) || (state == BACKOFF);
    // fires on the edge where the TIMEOUT_CYCLES-th silent cycle completes
    assign timeout = moving && !distance_valid && (silence_cnt == SIL_LAST);
    assign fault   = fault_q;

    always_ff @(posedge clk) begin
        if (rst || distance_valid || !moving)
            silence_cnt <= '0;
        else if (silence_cnt != SIL_LAST)
            silence_cnt <= silence_cnt + SW'(1);
    end
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dir_q  <= DIR_STOP;
            bo_cnt <= '0;
            dw_cnt <= '0;
`ifdef SENSOR_WATCHDOG_EN
            fault_q <= 1'b0;
`endif
        end else if (stop_cmd) begin
            state <= IDLE;
            dir_q <= DIR_STOP;
`ifdef SENSOR_WATCHDOG_EN
        end else if (timeout) begin
            state   <= IDLE;
            dir_q   <= DIR_STOP;
            fault_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd && !obstacle) begin
                        state <= FORWARD;
                        dir_q <= DIR_FORWARD;
`ifdef SENSOR_WATCHDOG_EN
                        fault_q <= 1'b0;
`endif
                    end
                end
                FORWARD: begin
                    if (obstacle) begin
                        state  <= BACKOFF;
                        dir_q  <= DIR_REVERSE;
                        bo_cnt <= BO_LOAD;
                    end
                end
                BACKOFF: begin
                    if (bo_cnt == '0) begin
                        state  <= WAIT;
                        dir_q  <= DIR_STOP;
                        dw_cnt <= DW_LOAD;
                    end else begin
                        bo_cnt <= bo_cnt - BW'(1);
                    end
                end
                WAIT: begin
                    if (dw_cnt != '0) begin
                        dw_cnt <= dw_cnt - DW'(1);
                    end else if (!obstacle) begin
                        state <= FORWARD;
                        dir_q <= DIR_FORWARD;
                    end
                end
                default: begin
                    state <= IDLE;
                    dir_q <= DIR_STOP;
                end
            endcase
        end
    end

    assign direction = dir_q;
    assign state_o   = state;

endmodule
